// File: rtl/vram_arbiter.sv
// Single-port video text RAM arbiter: display fetches take absolute priority with fixed latency,
// the terminal writer fills free slots via req/ack, and a monitor flags long writer waits.
module vram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_valid,
  output logic [DATA_W-1:0] o_disp_data,
  input  logic              i_wr_req,
  input  logic              i_wr_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_wr_starve,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, DISP, WRITE, READ} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_WR} tag_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              wr_ack;

  // The state register doubles as the RAM command and the writer ack.
  assign wr_ack      = (state_reg == WRITE) || (state_reg == READ);
  assign o_wr_ack    = wr_ack;
  assign o_mem_en    = (state_reg != IDLE);
  assign o_mem_we    = (state_reg == WRITE);
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_wdata = mem_wdata_reg;

  always_comb begin
    state_next     = IDLE;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if (i_disp_req) begin
      state_next    = DISP;
      mem_addr_next = i_disp_addr;
    end else if (i_wr_req && !wr_ack) begin
      // A request still high during its own ack cycle is not granted again.
      state_next    = i_wr_we ? WRITE : READ;
      mem_addr_next = i_wr_addr;
      if (i_wr_we) begin
        mem_wdata_next = i_wr_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Owner tags travel alongside each read so returning data can be steered.
  tag_t tag_in;
  tag_t tag_reg  [MEM_LAT+1];
  tag_t tag_next [MEM_LAT+1];

  always_comb begin
    tag_in = TAG_NONE;
    case (state_next)
      DISP:    tag_in = TAG_DISP;
      READ:    tag_in = TAG_WR;
      default: tag_in = TAG_NONE;
    endcase
  end

  assign tag_next[0] = tag_in;
  for (genvar gi = 1; gi <= MEM_LAT; gi++) begin : g_tag_shift
    assign tag_next[gi] = tag_reg[gi-1];
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i <= MEM_LAT; i++) begin
      if (i_rst) begin
        tag_reg[i] <= TAG_NONE;
      end else begin
        tag_reg[i] <= tag_next[i];
      end
    end
  end

  logic              disp_valid_reg, rd_valid_reg;
  logic [DATA_W-1:0] disp_data_reg, rd_data_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      disp_valid_reg <= 1'b0;
      disp_data_reg  <= '0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
    end else begin
      disp_valid_reg <= (tag_reg[MEM_LAT] == TAG_DISP);
      rd_valid_reg   <= (tag_reg[MEM_LAT] == TAG_WR);
      if (tag_reg[MEM_LAT] == TAG_DISP) begin
        disp_data_reg <= i_mem_rdata;
      end
      if (tag_reg[MEM_LAT] == TAG_WR) begin
        rd_data_reg <= i_mem_rdata;
      end
    end
  end

  assign o_disp_valid = disp_valid_reg;
  assign o_disp_data  = disp_data_reg;
  assign o_rd_valid   = rd_valid_reg;
  assign o_rd_data    = rd_data_reg;

  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             starve_reg, starve_next;

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!i_wr_req || wr_ack) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != CNT_W'(MAX_WAIT)) begin
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end
    starve_next = starve_reg || (wait_cnt_next == CNT_W'(MAX_WAIT));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt_reg <= '0;
      starve_reg   <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      starve_reg   <= starve_next;
    end
  end

  assign o_wr_starve = starve_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized and directed bench for vram_arbiter: a transaction-level model predicts grants
// and read returns into queues that a negedge monitor pops and compares.
module tb_vram_arbiter;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int MEM_LAT  = 2;
  localparam int MAX_WAIT = 64;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_disp_req;
  logic [ADDR_W-1:0] i_disp_addr;
  logic              o_disp_valid;
  logic [DATA_W-1:0] o_disp_data;
  logic              i_wr_req;
  logic              i_wr_we;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ack;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_wr_starve;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_disp_req(i_disp_req), .i_disp_addr(i_disp_addr),
    .o_disp_valid(o_disp_valid), .o_disp_data(o_disp_data),
    .i_wr_req(i_wr_req), .i_wr_we(i_wr_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_wr_starve(o_wr_starve),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with MEM_LAT read latency.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [0:MEM_LAT-1];
  always @(posedge i_clk) begin
    if (o_mem_en && o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
    rd_pipe[0] <= ram[o_mem_addr];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_mem_rdata = rd_pipe[MEM_LAT-1];

  int tot = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tot++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h cyc=%0d", name, got, want, cyc);
    end
  endtask

  // Reference model state: expected view of RAM contents and of the outputs after the next edge.
  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t              disp_q[$];
  ret_t              rd_q[$];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  logic              exp_ack = 0, exp_en = 0, exp_we = 0, exp_starve = 0;
  logic [ADDR_W-1:0] exp_addr = 0;
  logic [DATA_W-1:0] exp_wdata = 0;
  logic [DATA_W-1:0] hold_disp = 0, hold_rd = 0;
  int                wait_n = 0;

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) begin
      ram[i]    <= DATA_W'(i * 7 + 16'h0300);
      shadow[i]  = DATA_W'(i * 7 + 16'h0300);
    end
    ram[12'h010]    <= 16'h0741;
    shadow[12'h010]  = 16'h0741;
  end

  // Monitor then model, once per cycle on the falling edge.
  initial begin
    ret_t it;
    logic ev;
    logic waiting;
    forever begin
      @(negedge i_clk);
      chk("ack", o_wr_ack, exp_ack);
      chk("mem_en", o_mem_en, exp_en);
      chk("mem_we", o_mem_we, exp_we);
      if (exp_en) chk("mem_addr", o_mem_addr, exp_addr);
      if (exp_en && exp_we) chk("mem_wdata", o_mem_wdata, exp_wdata);
      chk("starve", o_wr_starve, exp_starve);
      if (o_wr_ack) $display("wr grant cyc=%0d we=%0b addr=%0h", cyc, o_mem_we, o_mem_addr);

      ev = (disp_q.size() > 0) && (disp_q[0].due == cyc);
      chk("disp_valid", o_disp_valid, ev);
      if (ev) begin
        it = disp_q.pop_front();
        hold_disp = it.data;
        $display("disp return cyc=%0d data=%0h", cyc, o_disp_data);
      end
      chk("disp_data", o_disp_data, hold_disp);

      ev = (rd_q.size() > 0) && (rd_q[0].due == cyc);
      chk("rd_valid", o_rd_valid, ev);
      if (ev) begin
        it = rd_q.pop_front();
        hold_rd = it.data;
        $display("wr read return cyc=%0d data=%0h", cyc, o_rd_data);
      end
      chk("rd_data", o_rd_data, hold_rd);

      if (i_rst) begin
        disp_q.delete();
        rd_q.delete();
        exp_ack = 0; exp_en = 0; exp_we = 0; exp_starve = 0;
        exp_addr = 0; exp_wdata = 0; hold_disp = 0; hold_rd = 0; wait_n = 0;
      end else begin
        waiting = i_wr_req && !exp_ack;
        wait_n  = waiting ? ((wait_n < MAX_WAIT) ? wait_n + 1 : MAX_WAIT) : 0;
        if (wait_n >= MAX_WAIT) exp_starve = 1;
        if (i_disp_req) begin
          exp_en = 1; exp_we = 0; exp_ack = 0; exp_addr = i_disp_addr;
          disp_q.push_back('{cyc + MEM_LAT + 2, shadow[i_disp_addr]});
        end else if (waiting) begin
          exp_en = 1; exp_we = i_wr_we; exp_ack = 1; exp_addr = i_wr_addr;
          if (i_wr_we) begin
            exp_wdata = i_wr_data;
            shadow[i_wr_addr] = i_wr_data;
          end else begin
            rd_q.push_back('{cyc + MEM_LAT + 2, shadow[i_wr_addr]});
          end
        end else begin
          exp_en = 0; exp_we = 0; exp_ack = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic new_wr();
    i_wr_req  = 1'b1;
    i_wr_we   = 1'($urandom_range(0, 1));
    i_wr_addr = ADDR_W'($urandom_range(0, 31));
    i_wr_data = DATA_W'($urandom);
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      i_disp_req  = ($urandom_range(0, 99) < 30);
      i_disp_addr = ADDR_W'($urandom_range(0, 31));
      if (i_wr_req && o_wr_ack) begin
        if ($urandom_range(0, 1) == 0) i_wr_req = 1'b0;
        else new_wr();
      end else if (!i_wr_req && $urandom_range(0, 99) < 40) begin
        new_wr();
      end
      step();
    end
  endtask

  task automatic drain();
    i_disp_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (i_wr_req && o_wr_ack) i_wr_req = 1'b0;
      step();
    end
  endtask

  int                pulses, at, acks, seen, ack_at, dv_at, rv_at;
  logic [DATA_W-1:0] dat;
  logic [6:0]        pattern;

  initial begin
    i_rst = 1'b1; i_disp_req = 1'b0; i_disp_addr = '0;
    i_wr_req = 1'b0; i_wr_we = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    repeat (3) step();
    i_rst = 1'b0;
    step(); step();

    $display("test1 display fetch of 0x010");
    i_disp_req = 1'b1; i_disp_addr = 12'h010;
    step();
    i_disp_req = 1'b0;
    chk("t1_mem_en", o_mem_en, 1);
    chk("t1_mem_addr", o_mem_addr, 12'h010);
    pulses = 0; at = 0; dat = '0;
    for (int k = 1; k <= 8; k++) begin
      if (o_disp_valid) begin pulses++; at = k; dat = o_disp_data; end
      step();
    end
    chk("t1_pulses", pulses, 1);
    chk("t1_latency", at, MEM_LAT + 2);
    chk("t1_data", dat, 16'h0741);

    $display("test2 writer write then read of 0x123");
    i_wr_req = 1'b1; i_wr_we = 1'b1; i_wr_addr = 12'h123; i_wr_data = 16'h1F41;
    step();
    chk("t2_ack", o_wr_ack, 1);
    chk("t2_we", o_mem_we, 1);
    chk("t2_addr", o_mem_addr, 12'h123);
    chk("t2_wdata", o_mem_wdata, 16'h1F41);
    i_wr_req = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      if (o_rd_valid) pulses++;
      step();
    end
    chk("t2_no_rd_valid", pulses, 0);
    i_wr_req = 1'b1; i_wr_we = 1'b0;
    step();
    chk("t2_rd_ack", o_wr_ack, 1);
    i_wr_req = 1'b0;
    pulses = 0; at = 0; dat = '0;
    for (int k = 1; k <= 7; k++) begin
      if (o_rd_valid) begin pulses++; at = k; dat = o_rd_data; end
      step();
    end
    chk("t2_rd_pulses", pulses, 1);
    chk("t2_rd_latency", at, MEM_LAT + 2);
    chk("t2_rd_data", dat, 16'h1F41);

    $display("test3 simultaneous display and writer requests");
    i_disp_req = 1'b1; i_disp_addr = 12'h005;
    i_wr_req = 1'b1; i_wr_we = 1'b0; i_wr_addr = 12'h007;
    ack_at = 0; dv_at = 0; rv_at = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        i_disp_req = 1'b0;
        chk("t3_disp_first", o_mem_addr, 12'h005);
      end
      if (o_wr_ack && ack_at == 0) begin ack_at = k; i_wr_req = 1'b0; end
      if (o_disp_valid) dv_at = k;
      if (o_rd_valid) rv_at = k;
    end
    chk("t3_ack_at", ack_at, 2);
    chk("t3_disp_at", dv_at, MEM_LAT + 2);
    chk("t3_rd_at", rv_at, 2 + MEM_LAT + 1);

    $display("test4 writer holds request after ack");
    i_wr_req = 1'b1; i_wr_we = 1'b1; i_wr_addr = 12'h020; i_wr_data = 16'hABCD;
    pattern = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      pattern[k] = o_wr_ack;
      if (k == 4) i_wr_req = 1'b0;
    end
    chk("t4_ack_pattern", pattern, 7'b0001010);

    $display("test5 random traffic");
    random_phase(800);
    drain();

    $display("test6 display strobes every cycle, writer starves");
    i_wr_req = 1'b1; i_wr_we = 1'b1; i_wr_addr = 12'h030; i_wr_data = 16'h5555;
    acks = 0;
    for (int k = 1; k <= 70; k++) begin
      i_disp_req  = 1'b1;
      i_disp_addr = ADDR_W'($urandom_range(0, 31));
      step();
      if (o_wr_ack) acks++;
      if (k == 30) chk("t6_no_starve_early", o_wr_starve, 0);
    end
    chk("t6_no_ack", acks, 0);
    chk("t6_starve_set", o_wr_starve, 1);
    i_disp_req = 1'b0;
    seen = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (o_wr_ack && seen == 0) begin seen = 1; i_wr_req = 1'b0; end
    end
    chk("t6_ack_after", seen, 1);
    repeat (3) step();
    chk("t6_starve_sticky", o_wr_starve, 1);

    $display("test7 reset with reads in flight");
    i_disp_req = 1'b1; i_disp_addr = 12'h010;
    step();
    i_disp_req = 1'b0;
    i_wr_req = 1'b1; i_wr_we = 1'b0; i_wr_addr = 12'h011;
    step();
    chk("t7_rd_ack", o_wr_ack, 1);
    i_wr_req = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("t7_mem_en", o_mem_en, 0);
    chk("t7_mem_we", o_mem_we, 0);
    chk("t7_mem_addr", o_mem_addr, 0);
    chk("t7_mem_wdata", o_mem_wdata, 0);
    chk("t7_disp_valid", o_disp_valid, 0);
    chk("t7_disp_data", o_disp_data, 0);
    chk("t7_ack", o_wr_ack, 0);
    chk("t7_rd_valid", o_rd_valid, 0);
    chk("t7_rd_data", o_rd_data, 0);
    chk("t7_starve", o_wr_starve, 0);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      if (o_disp_valid || o_rd_valid) pulses++;
      step();
    end
    chk("t7_no_late_valid", pulses, 0);

    $display("test8 random traffic after reset");
    random_phase(300);
    drain();
    chk("drain_disp_q", disp_q.size(), 0);
    chk("drain_rd_q", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Arbitrates a single-port video text RAM between two requesters:
- the display fetch path, which runs in lockstep with the 640x480 sync/pixel counters and reads one character cell per 8-pixel strobe;
- the terminal writer, which performs cell reads and writes for the virtual console.

Display fetches have absolute priority and a fixed, deterministic latency. The writer is served in the remaining slots through a req/ack handshake, and a starvation monitor watches its wait time.

Parameters:
ADDR_W, 12, cell address width (80x30 = 2400 cells fit)
DATA_W, 16, cell width (char code [7:0], attribute [15:8])
MEM_LAT, 2, RAM read latency in cycles from o_mem_en (we=0) to valid i_mem_rdata; legal range 1..4
MAX_WAIT, 64, writer wait cycles without grant before o_wr_starve sets

Ports:
i_clk  in  1  system clock (same domain as pixel strobe logic)
i_rst  in  1  synchronous active-high reset
i_disp_req  in  1  single-cycle display fetch strobe
i_disp_addr  in  ADDR_W  display fetch cell address
o_disp_valid  out  1  one-cycle pulse, o_disp_data valid
o_disp_data  out  DATA_W  fetched display cell
i_wr_req  in  1  writer request, level, held until o_wr_ack
i_wr_we  in  1  1 = write, 0 = read
i_wr_addr  in  ADDR_W  writer cell address
i_wr_data  in  DATA_W  writer write data
o_wr_ack  out  1  one-cycle grant pulse
o_rd_valid  out  1  one-cycle pulse, o_rd_data valid (writer reads only)
o_rd_data  out  DATA_W  writer read data
o_wr_starve  out  1  sticky starvation flag
o_mem_en  out  1  RAM enable
o_mem_we  out  1  RAM write enable
o_mem_addr  out  ADDR_W  RAM address
o_mem_wdata  out  DATA_W  RAM write data
i_mem_rdata  in  DATA_W  RAM read data

Behaviour:
Reset (synchronous, any cycle):
- All outputs go to 0: o_mem_*, o_disp_valid, o_disp_data, o_wr_ack, o_rd_valid, o_rd_data, o_wr_starve.
- The in-flight tag pipeline and the wait counter are cleared.
- No valid pulse may emerge after reset for any request issued before it, including reset mid-read.

Grant FSM, per cycle (states: IDLE, DISP, WRITE, READ):
- i_disp_req=1 -> DISP; o_mem_en=1, we=0, addr=i_disp_addr registered next cycle.
- else i_wr_req=1 and o_wr_ack was 0 in the previous cycle -> WRITE or READ; o_mem_* registered next cycle; o_wr_ack=1 in the same registered cycle.
- else IDLE; o_mem_en=0 and o_mem_we=0.
- A writer request is granted at most once per handshake. After the ack cycle, the writer must deassert or present a new request. A request still high in the cycle after ack is treated as new only from the following cycle; there is no back-to-back double grant of one request.

Issue slot:
- A display request sampled at edge N drives o_mem_* during cycle N+1.
- Display always wins a simultaneous request; the writer retries the next free cycle.
- Consecutive display strobes on every cycle are all served, and the writer stalls.

Return path:
- A (MEM_LAT+1)-deep tag shift register records the owner of each issued read: none, disp or wr.
- The tag reaching the end captures i_mem_rdata into o_disp_data or o_rd_data (registered).
- The matching valid pulses for one cycle.
- Display latency from sampled i_disp_req to o_disp_valid is exactly MEM_LAT+2 cycles (4 at default), independent of writer traffic.
- Writes produce no read-valid.
- Data outputs hold their last value between pulses.

Starvation monitor:
- A wait counter increments each cycle that i_wr_req=1 without ack, and clears on ack or when i_wr_req=0.
- When the counter reaches MAX_WAIT, o_wr_starve sets and stays set until reset.
- The counter saturates and does not wrap.

Ordering:
- A writer write followed by a display read of the same address returns the new data, because RAM access is in issue order.

Test Plan:
- Reset, then i_disp_req with addr 0x010 at edge N, RAM holding 0x0741 -> o_mem_en=1, addr 0x010 in cycle N+1; o_disp_valid=1, o_disp_data=0x0741 at N+4; single pulse only.
- Writer write 0x1F41 to 0x123 while idle -> o_wr_ack one cycle with o_mem_we=1, addr 0x123, wdata 0x1F41; no o_rd_valid; a later writer read of 0x123 -> o_rd_valid with 0x1F41 at ack cycle +MEM_LAT+1.
- Display and writer requests in the same cycle -> display issued first, writer ack exactly one cycle later; o_disp_valid timing unchanged at +4.
- Display strobes every cycle for 70 cycles with writer held -> no ack, o_wr_starve rises after 64 waiting cycles and stays 1 after strobes stop and the writer is acked.
- Assert i_rst one cycle after a display and a writer read are issued -> no o_disp_valid/o_rd_valid afterwards, all outputs 0 the cycle after reset.
- Writer holds i_wr_req for 3 cycles after ack with no display traffic -> exactly two acks (cycles 1 and 3), never in adjacent cycles.
